// File: rtl/note_sequencer_pkg.sv
// Shared types, sizes and slot-extraction helpers for the note sequencer.
// Slot i of a packed pattern vector lives at [W*i +: W].
package note_seq_pkg;

  localparam int NUM_NOTES = 24;
  localparam int TIMING_W  = 3;
  localparam int SPEED_W   = 3;
  localparam int DIR_W     = 2;
  localparam int TURN_W    = 4;
  localparam int IDX_W     = 5;

  localparam int TV_W = NUM_NOTES * TIMING_W;
  localparam int SV_W = NUM_NOTES * SPEED_W;
  localparam int DV_W = NUM_NOTES * DIR_W;

  localparam int TB_W = $clog2(TV_W);
  localparam int SB_W = $clog2(SV_W);
  localparam int DB_W = $clog2(DV_W);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]   index;
    logic [SPEED_W-1:0] speed;
    logic [DIR_W-1:0]   direction;
    logic               inversed;
  } note_t;

  function automatic logic [TIMING_W-1:0] slot_timing(input logic [TV_W-1:0]  vec,
                                                      input logic [IDX_W-1:0] idx);
    logic [TB_W-1:0] base;
    base = TB_W'(TIMING_W * idx);
    return vec[base +: TIMING_W];
  endfunction

  function automatic logic [SPEED_W-1:0] slot_speed(input logic [SV_W-1:0]  vec,
                                                    input logic [IDX_W-1:0] idx);
    logic [SB_W-1:0] base;
    base = SB_W'(SPEED_W * idx);
    return vec[base +: SPEED_W];
  endfunction

  function automatic logic [DIR_W-1:0] slot_dir(input logic [DV_W-1:0]  vec,
                                                input logic [IDX_W-1:0] idx);
    logic [DB_W-1:0] base;
    base = DB_W'(DIR_W * idx);
    return vec[base +: DIR_W];
  endfunction

  function automatic note_t make_note(input logic [SV_W-1:0]      spd,
                                     input logic [DV_W-1:0]      dir,
                                     input logic [NUM_NOTES-1:0] inv,
                                     input logic [IDX_W-1:0]     idx);
    note_t n;
    n.index     = idx;
    n.speed     = slot_speed(spd, idx);
    n.direction = slot_dir(dir, idx);
    n.inversed  = inv[idx];
    return n;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, pattern-ROM and note-spawn signals of the note sequencer.
// slave = the sequencer itself; master = game FSM / ROM bank / renderer side.
interface note_sequencer_if;
  import note_seq_pkg::*;

  logic                   start_in;
  logic                   stop_in;
  logic [TURN_W-1:0]      turn_in;
  logic                   tick_in;
  logic                   pattern_valid_in;
  logic [TV_W-1:0]        timing_in;
  logic [SV_W-1:0]        speed_in;
  logic [DV_W-1:0]        direction_in;
  logic [NUM_NOTES-1:0]   inversed_in;

  logic [TURN_W-1:0]      turn_out;
  logic                   note_valid_out;
  logic [IDX_W-1:0]       note_index_out;
  logic [SPEED_W-1:0]     note_speed_out;
  logic [DIR_W-1:0]       note_direction_out;
  logic                   note_inversed_out;
  logic                   busy_out;
  logic                   done_out;
  logic                   error_out;

  modport slave (
    input  start_in, stop_in, turn_in, tick_in, pattern_valid_in,
           timing_in, speed_in, direction_in, inversed_in,
    output turn_out, note_valid_out, note_index_out, note_speed_out,
           note_direction_out, note_inversed_out, busy_out, done_out, error_out
  );

  modport master (
    output start_in, stop_in, turn_in, tick_in, pattern_valid_in,
           timing_in, speed_in, direction_in, inversed_in,
    input  turn_out, note_valid_out, note_index_out, note_speed_out,
           note_direction_out, note_inversed_out, busy_out, done_out, error_out
  );

endinterface

// File: rtl/note_sequencer.sv
// Fetches the pattern for a turn, then plays its 24 slots paced by beat ticks.
// Build option NOTE_SKIP_EN: speed-0 slots keep their timing but raise no strobe.
module note_sequencer
  import note_seq_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  note_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

  state_t               state_q, state_d;
  logic [TURN_W-1:0]    turn_q;
  logic                 error_q;
  logic [IDX_W-1:0]     index_q;
  logic [TIMING_W-1:0]  wait_q;
  logic [TV_W-1:0]      timing_q;
  logic [SV_W-1:0]      speed_q;
  logic [DV_W-1:0]      direction_q;
  logic [NUM_NOTES-1:0] inversed_q;
  note_t                note_q;

  logic                 busy_state;
  logic                 wait_done;
  logic [IDX_W-1:0]     next_idx;

  assign busy_state = (state_q == FETCH) || (state_q == WAIT) || (state_q == EMIT);
  // The tick that takes the count from 1 to 0 already releases the slot.
  assign wait_done  = (wait_q == '0) || (bus.tick_in && (wait_q == TIMING_W'(1)));
  assign next_idx   = index_q + IDX_W'(1);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_in) state_d = FETCH;
      FETCH:   state_d = bus.pattern_valid_in ? WAIT : DONE;
      WAIT:    if (wait_done) state_d = EMIT;
      EMIT:    state_d = (index_q == LAST_IDX) ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.stop_in && busy_state) state_d = DONE;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      turn_q      <= '0;
      error_q     <= 1'b0;
      index_q     <= '0;
      wait_q      <= '0;
      // NOTE: the pattern copies are ordinary flops, not a RAM, so clearing them on reset is cheap and keeps note fields at 0.
      timing_q    <= '0;
      speed_q     <= '0;
      direction_q <= '0;
      inversed_q  <= '0;
      note_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            turn_q  <= bus.turn_in;
            error_q <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.pattern_valid_in) begin
            timing_q    <= bus.timing_in;
            speed_q     <= bus.speed_in;
            direction_q <= bus.direction_in;
            inversed_q  <= bus.inversed_in;
            index_q     <= '0;
            wait_q      <= slot_timing(bus.timing_in, '0);
          end else begin
            error_q <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.tick_in && (wait_q != '0)) wait_q <= wait_q - TIMING_W'(1);
        end
        EMIT: begin
          // Ticks during EMIT are dropped: the next count is loaded fresh.
          if (index_q != LAST_IDX) begin
            index_q <= next_idx;
            wait_q  <= slot_timing(timing_q, next_idx);
          end
        end
        default: ;
      endcase
      if (state_d == EMIT) note_q <= make_note(speed_q, direction_q, inversed_q, index_q);
    end
  end

  always_comb begin
    bus.note_valid_out = (state_q == EMIT);
`ifdef NOTE_SKIP_EN
    if (note_q.speed == '0) bus.note_valid_out = 1'b0;
`endif
  end

  assign bus.turn_out           = turn_q;
  assign bus.note_index_out     = note_q.index;
  assign bus.note_speed_out     = note_q.speed;
  assign bus.note_direction_out = note_q.direction;
  assign bus.note_inversed_out  = note_q.inversed;
  assign bus.busy_out           = (state_q != IDLE);
  assign bus.done_out           = (state_q == DONE);
  assign bus.error_out          = error_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a slot-level timing model predicts each
// strobe (fields and cycle); a monitor pops and compares whenever a strobe appears.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int MAXC = 600;
`ifdef NOTE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int idx;
    int spd;
    int dir;
    int inv;
    int cyc;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  note_sequencer_if bus();
  note_sequencer dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Pattern ROM stub: one turn hits, everything else misses.
  int rom_turn = 3;
  int rom_tim[NUM_NOTES];
  int rom_spd[NUM_NOTES];
  int rom_dir[NUM_NOTES];
  int rom_inv[NUM_NOTES];

  always_comb begin
    bus.timing_in    = '0;
    bus.speed_in     = '0;
    bus.direction_in = '0;
    bus.inversed_in  = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      bus.timing_in[TIMING_W*i +: TIMING_W] = TIMING_W'(rom_tim[i]);
      bus.speed_in[SPEED_W*i +: SPEED_W]    = SPEED_W'(rom_spd[i]);
      bus.direction_in[DIR_W*i +: DIR_W]    = DIR_W'(rom_dir[i]);
      bus.inversed_in[i]                    = rom_inv[i][0];
    end
    bus.pattern_valid_in = (int'(bus.turn_out) == rom_turn);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk_in) begin
    if (bus.note_valid_out === 1'b1) begin
      check("strobe_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("note_index",     int'(bus.note_index_out),     mon_e.idx);
        check("note_speed",     int'(bus.note_speed_out),     mon_e.spd);
        check("note_direction", int'(bus.note_direction_out), mon_e.dir);
        check("note_inversed",  int'(bus.note_inversed_out),  mon_e.inv);
        check("note_cycle",     cyc,                          mon_e.cyc);
      end
    end
  end

  bit tick_sched[MAXC];

  task automatic ticks_every(input int period, input int first);
    for (int r = 0; r < MAXC; r++) tick_sched[r] = (r >= first) && ((r - first) % period == 0);
  endtask

  task automatic ticks_none();
    for (int r = 0; r < MAXC; r++) tick_sched[r] = 1'b0;
  endtask

  task automatic ticks_random(input int pct);
    for (int r = 0; r < MAXC; r++) tick_sched[r] = ($urandom_range(99) < pct);
  endtask

  task automatic load_stub(input int tim);
    for (int i = 0; i < NUM_NOTES; i++) begin
      rom_tim[i] = tim;
      rom_spd[i] = i % 8;
      rom_dir[i] = i % 4;
      rom_inv[i] = i % 2;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NUM_NOTES; i++) begin
      rom_tim[i] = $urandom_range(3);
      rom_spd[i] = $urandom_range(7);
      rom_dir[i] = $urandom_range(3);
      rom_inv[i] = $urandom_range(1);
    end
  endtask

  // One playback. *_rel are cycle offsets from the start cycle; -1 disables.
  task automatic run(input int turn, input int stop_rel, input int dup_rel,
                     input int rst_rel, input bit scramble);
    int m_tim[NUM_NOTES];
    int m_spd[NUM_NOTES];
    int m_dir[NUM_NOTES];
    int m_inv[NUM_NOTES];
    int e_cyc[NUM_NOTES];
    bit hit;
    int s, f, done_c, prev, c, cnt, end_c, busy_end, stop_c, rst_c;
    exp_t x;

    m_tim = rom_tim;
    m_spd = rom_spd;
    m_dir = rom_dir;
    m_inv = rom_inv;
    hit   = (turn == rom_turn);

    @(negedge clk_in);
    s      = cyc;
    f      = s + 1;
    stop_c = (stop_rel >= 0) ? s + stop_rel : -1;
    rst_c  = (rst_rel  >= 0) ? s + rst_rel  : -1;
    done_c = -1;
    for (int i = 0; i < NUM_NOTES; i++) e_cyc[i] = -1;

    // Slot model: timing 0 fires two cycles after the previous event; timing t
    // fires one cycle after the t-th tick seen strictly after the previous event.
    if (!hit) begin
      done_c = f + 1;
    end else begin
      prev = f;
      for (int i = 0; i < NUM_NOTES && prev >= 0; i++) begin
        if (m_tim[i] == 0) begin
          e_cyc[i] = prev + 2;
        end else begin
          cnt = 0;
          c   = prev;
          while (cnt < m_tim[i] && c < s + MAXC - 1) begin
            c++;
            if (tick_sched[c - s]) cnt++;
          end
          e_cyc[i] = (cnt == m_tim[i]) ? c + 1 : -1;
        end
        prev = e_cyc[i];
      end
      if (prev >= 0) done_c = prev + 1;
    end

    if (stop_c >= 0) begin
      for (int i = 0; i < NUM_NOTES; i++) if (e_cyc[i] > stop_c) e_cyc[i] = -1;
      if (done_c < 0 || done_c > stop_c + 1) done_c = stop_c + 1;
    end
    if (rst_c >= 0) begin
      for (int i = 0; i < NUM_NOTES; i++) if (e_cyc[i] > rst_c) e_cyc[i] = -1;
      if (done_c > rst_c) done_c = -1;
    end

    busy_end = (done_c >= 0) ? done_c : ((rst_c >= 0) ? rst_c : s + MAXC);
    end_c    = ((done_c >= 0) ? done_c : ((rst_c >= 0) ? rst_c : s + MAXC - 4)) + 3;

    for (int i = 0; i < NUM_NOTES; i++) begin
      if (e_cyc[i] >= 0 && !(SKIP && m_spd[i] == 0)) begin
        x.idx = i;
        x.spd = m_spd[i];
        x.dir = m_dir[i];
        x.inv = m_inv[i];
        x.cyc = e_cyc[i];
        sb.push_back(x);
      end
    end

    for (int rel = 0; rel < MAXC && s + rel <= end_c; rel++) begin
      if (rel > 0) @(negedge clk_in);
      c = s + rel;
      check("busy", int'(bus.busy_out), int'(c >= f && c <= busy_end));
      check("done", int'(bus.done_out), int'(c == done_c));
      if (c == f) begin
        check("error_cleared", int'(bus.error_out), 0);
        check("turn_out", int'(bus.turn_out), turn);
      end
      if (c == done_c) check("error_at_done", int'(bus.error_out), int'(!hit));
      if (rst_c >= 0 && c == rst_c + 1) begin
        check("rst_turn",  int'(bus.turn_out),           0);
        check("rst_valid", int'(bus.note_valid_out),     0);
        check("rst_index", int'(bus.note_index_out),     0);
        check("rst_speed", int'(bus.note_speed_out),     0);
        check("rst_dir",   int'(bus.note_direction_out), 0);
        check("rst_inv",   int'(bus.note_inversed_out),  0);
        check("rst_error", int'(bus.error_out),          0);
      end
      bus.start_in = (rel == 0) || (rel == dup_rel);
      bus.turn_in  = (rel == 0) ? TURN_W'(turn) : TURN_W'(9);
      bus.tick_in  = tick_sched[rel];
      bus.stop_in  = (rel == stop_rel);
      rst_in       = (rel == rst_rel);
      if (scramble && rel == 3) load_random();
    end

    bus.start_in = 1'b0;
    bus.tick_in  = 1'b0;
    bus.stop_in  = 1'b0;
    rst_in       = 1'b0;
    repeat (2) @(negedge clk_in);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    bus.tick_in  = 1'b0;
    bus.turn_in  = '0;
    load_stub(1);

    repeat (3) @(negedge clk_in);
    check("reset_turn",  int'(bus.turn_out),           0);
    check("reset_valid", int'(bus.note_valid_out),     0);
    check("reset_index", int'(bus.note_index_out),     0);
    check("reset_speed", int'(bus.note_speed_out),     0);
    check("reset_dir",   int'(bus.note_direction_out), 0);
    check("reset_inv",   int'(bus.note_inversed_out),  0);
    check("reset_busy",  int'(bus.busy_out),           0);
    check("reset_done",  int'(bus.done_out),           0);
    check("reset_error", int'(bus.error_out),          0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Basic playback: timing 1 everywhere, one tick every 10 cycles.
    load_stub(1);
    ticks_every(10, 5);
    run(3, -1, -1, -1, 1'b0);

    // Back-to-back: timing 0, no ticks at all.
    load_stub(0);
    ticks_none();
    run(3, -1, -1, -1, 1'b0);

    // Miss, then a hit that must clear the sticky error.
    ticks_none();
    run(9, -1, -1, -1, 1'b0);
    load_stub(1);
    ticks_every(3, 2);
    run(3, -1, -1, -1, 1'b0);

    // Stop together with the tick that would release slot 5; a start while busy.
    load_stub(1);
    ticks_every(4, 3);
    run(3, 23, 10, -1, 1'b0);

    // Reset while slot 10 is waiting.
    load_stub(1);
    ticks_every(4, 3);
    run(3, -1, -1, 42, 1'b0);

    // Slot 2 empty (speed 0), all other speeds nonzero.
    load_stub(1);
    for (int i = 0; i < NUM_NOTES; i++) rom_spd[i] = (i % 7) + 1;
    rom_spd[2] = 0;
    ticks_every(5, 2);
    run(3, -1, -1, -1, 1'b0);

    // Random patterns and tick streams; the ROM changes under the sequencer.
    for (int k = 0; k < 4; k++) begin
      load_random();
      ticks_random(40);
      run(3, -1, -1, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog at cycle %0d: got timeout, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
